mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequencer sitting directly upstream/around the 2:1 select mux (inputs `i[1:0]`, select `s`, output `o`).
- Drives the mux select, dwells a programmable number of cycles on each channel, samples the mux output at the end of each dwell, and presents both samples as a 2-bit word with a one-cycle valid pulse.
- Used to scan two single-bit sources through one shared mux path into registered logic.

Parameters:
- DWELL, 4, cycles spent on each channel before sampling; legal range 1..2**CNT_W.
- CNT_W, 4, width of the dwell counter; must satisfy 2**CNT_W >= DWELL.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one scan; sampled only in IDLE.
- stop  input  1  synchronous abort; returns FSM to IDLE.
- mux_o  input  1  mux output fed back (connects to mux `o`).
- sel  output  1  mux select (connects to mux `s`); 0 = channel 0, 1 = channel 1.
- sample  output  2  captured result; bit0 = channel 0, bit1 = channel 1.
- valid  output  1  one-cycle pulse, sample updated and stable.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high, one clock; polarity and synchronicity fixed): state=IDLE, cnt=0, sel=0, sample=2'b00, valid=0, busy=0. Reset asserted mid-scan discards the scan; sample returns to 00.
- FSM states: IDLE, CH0, CH1, DONE. All outputs registered, driven from state and registers only.
- IDLE: sel=0, busy=0. start=1 at an edge -> CH0 with cnt=0.
- CH0: sel=0, busy=1. cnt increments each cycle. At the edge where cnt==DWELL-1: sample[0]<=mux_o, cnt<=0, -> CH1.
- CH1: sel=1, busy=1. Same counting. At the edge where cnt==DWELL-1: sample[1]<=mux_o, cnt<=0, -> DONE.
- DONE: valid=1 for exactly this cycle, sel=0, busy=1 -> IDLE next edge.
- Latency: start edge to valid cycle = 2*DWELL+1 cycles. DWELL=4 gives CH0 for cycles 1-4, CH1 for cycles 5-8, valid in cycle 9.
- Sampling point: the last dwell cycle of each channel, so the mux has DWELL-1 settle cycles after a sel change.
- sample holds its value between scans. It is updated bitwise only at the two capture edges. Consumers use it only on valid.
- start outside IDLE is ignored (no queuing).
- stop=1 in CH0/CH1/DONE -> IDLE next edge. cnt=0; valid is not pulsed; sample bits already captured in this scan are kept.
- stop has priority over the capture at the same edge: no capture occurs.
- stop and start both high in IDLE -> stay IDLE.
- DWELL=1: one cycle per channel; latency 3.
- Counter never wraps, because it is cleared at DWELL-1.

Optional Feature:
- Macro MUX_SCAN_CONTINUOUS_EN.
- Defined: DONE transitions to CH0 (not IDLE) unless stop=1. Scans repeat back-to-back with valid every 2*DWELL+1 cycles. start is needed only for the first scan. busy stays high until stop.
- Undefined: single-shot behaviour as above.

Decomposition:
- Package mux_scan_pkg holds:
  - State encoding constants: IDLE=2'd0, CH0=2'd1, CH1=2'd2, DONE=2'd3.
  - Channel index constants: CH_SEL0=1'b0, CH_SEL1=1'b1.
- One natural sub-module: mux_scan_dwell_cnt. It is a CNT_W-bit counter with clr/en inputs and a registered-compare output last=(cnt==DWELL-1), using the same clk/rst.
- The top contains only the FSM, the sel decode and the sample/valid registers.

Test Plan:
- Reset mid-scan: assert rst during cycle 3 of CH1 -> sel=0, busy=0, valid=0, sample=00 immediately; no valid pulse afterwards.
- Basic scan, DWELL=4, mux_o = sel (ch0=0, ch1=1): start pulse at edge 0 -> sel=0 in cycles 1-4, sel=1 in cycles 5-8, valid=1 only in cycle 9 with sample=2'b10, busy low from cycle 10.
- Settle check: mux_o toggled every cycle during CH0 and stable at 1 in the last dwell cycle -> sample[0]=1. Likewise 0 in CH1's last cycle -> sample[1]=0.
- Abort: stop=1 in cycle 6 (CH1) -> IDLE in cycle 7, no valid, sample[0] keeps cycle-4 value, sample[1] unchanged from the previous scan.
- Ignored start plus DWELL=1: start held high through a scan -> exactly one valid, at cycle 3. Re-issued start in IDLE gives a second scan whose valid is 3 cycles later.
- With MUX_SCAN_CONTINUOUS_EN, DWELL=2: single start -> valid in cycles 5, 10 and 15. stop in cycle 12 -> IDLE at 13, no further valid.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared encodings for the two-channel mux scan sequencer.
// The state and channel constants are used by mux_scan_ctrl.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic CH_SEL0 = 1'b0;
  localparam logic CH_SEL1 = 1'b1;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter for mux_scan_ctrl. The counter clears or increments each cycle.
// `last` is a registered flag that is high while cnt == DWELL-1.
module mux_scan_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: always_comb assigns cnt_nxt a default first, so no path infers a latch.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = cnt + CNT_W'(1);
  end

  // last is computed from the next count, so it stays aligned with cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      last <= (LAST_VAL == '0);
    end else begin
      cnt  <= cnt_nxt;
      last <= (cnt_nxt == LAST_VAL);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer that scans two sources through a shared 2:1 mux. It drives sel,
// dwells on each channel, captures mux_o, and pulses valid when the scan ends.
// Optional MUX_SCAN_CONTINUOUS_EN: scans repeat back-to-back until stop.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mux_o,
  output logic       sel,
  output logic [1:0] sample,
  output logic       valid,
  output logic       busy
);

  state_t state;
  logic   dwelling;
  logic   last;

  // While the FSM is not dwelling, the counter is held at zero.
  // Each channel therefore starts counting from a clean count.
  assign dwelling = (state == CH0) || (state == CH1);

  mux_scan_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!dwelling || stop || last),
    .en   (dwelling),
    .last (last)
  );

  // NOTE: all state and output registers use non-blocking assignments.
  // Each register updates from the values that were current before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= CH_SEL0;
      sample <= 2'b00;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= CH0;
            busy  <= 1'b1;
          end
          sel <= CH_SEL0;
        end
        CH0: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            sample[0] <= mux_o;
            state     <= CH1;
            sel       <= CH_SEL1;
          end
        end
        CH1: begin
          if (stop) begin
            state <= IDLE;
            sel   <= CH_SEL0;
            busy  <= 1'b0;
          end else if (last) begin
            sample[1] <= mux_o;
            state     <= DONE;
            sel       <= CH_SEL0;
            valid     <= 1'b1;
          end
        end
        DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CH0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          sel   <= CH_SEL0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl using three instances with DWELL = 4, 1 and 2.
// Cycle numbers count from the edge that accepts start (edge 0 begins cycle 1).
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, stop4, mux_mode, mux_force, mux_o4;
  logic       sel4, valid4, busy4;
  logic [1:0] sample4;
  logic       start1, stop1, mux_o1, sel1, valid1, busy1;
  logic [1:0] sample1;
  logic       start2, stop2, mux_o2, sel2, valid2, busy2;
  logic [1:0] sample2;

  assign mux_o4 = mux_mode ? sel4 : mux_force;
  assign mux_o1 = sel1;
  assign mux_o2 = sel2;

  mux_scan_ctrl #(.DWELL(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop4), .mux_o(mux_o4),
    .sel(sel4), .sample(sample4), .valid(valid4), .busy(busy4));

  mux_scan_ctrl #(.DWELL(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .mux_o(mux_o1),
    .sel(sel1), .sample(sample1), .valid(valid1), .busy(busy1));

  mux_scan_ctrl #(.DWELL(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .mux_o(mux_o2),
    .sel(sel2), .sample(sample2), .valid(valid2), .busy(busy2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] e;
    rst = 1'b1;
    {start4, stop4, start1, stop1, start2, stop2} = '0;
    mux_mode  = 1'b1;
    mux_force = 1'b0;
    step();
    step();
    check("rst_sel",    sel4,    0);
    check("rst_busy",   busy4,   0);
    check("rst_valid",  valid4,  0);
    check("rst_sample", sample4, 0);
    check("rst_busy2",  busy2,   0);
    rst = 1'b0;
    step();

`ifndef MUX_SCAN_CONTINUOUS_EN
    // If start and stop arrive together in IDLE, the FSM stays in IDLE.
    start4 = 1'b1; stop4 = 1'b1;
    step();
    start4 = 1'b0; stop4 = 1'b0;
    check("start_stop_idle", busy4, 0);

    // Basic scan: mux_o follows sel, so the captured word is 2'b10.
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      e = {1'(c >= 5 && c <= 8), 1'(c <= 9), 1'(c == 9)};
      check($sformatf("basic_sbv_c%0d", c), {sel4, busy4, valid4}, e);
      if (c == 9) check("basic_sample", sample4, 2'b10);
      step();
    end

    // Abort in CH1: sample[0] is captured as 1. sample[1] keeps 1 from the last scan.
    mux_mode = 1'b0; mux_force = 1'b1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 5) mux_force = 1'b0;
      if (c == 6) stop4 = 1'b1;
      if (c == 7) stop4 = 1'b0;
      if (c == 5) check("abort_sel_ch1", sel4, 1);
      if (c == 7) check("abort_idle", {sel4, busy4}, 2'b00);
      if (c >= 7) check($sformatf("abort_novalid_c%0d", c), valid4, 0);
      step();
    end
    check("abort_sample", sample4, 2'b11);

    // Settle check: mux_o toggles, and only the last dwell cycle of each channel is captured.
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 4)      mux_force = (c % 2 == 0);
      else if (c <= 8) mux_force = (c % 2 == 1);
      if (c == 9) begin
        check("settle_valid", valid4, 1);
        check("settle_sample", sample4, 2'b01);
      end
      if (c == 10) check("settle_hold", {valid4, sample4}, 3'b001);
      step();
    end

    // Reset asserted in the third CH1 cycle clears everything at once.
    mux_force = 1'b1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 6; c++) step();
    check("prerst_sel", sel4, 1);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {sel4, busy4, valid4, sample4}, 5'b00000);
    step();
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("postrst_c%0d", c), {valid4, busy4}, 2'b00);
      step();
    end

    // DWELL=1: start is held through the scan, so it is ignored outside IDLE.
    start1 = 1'b1;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) start1 = 1'b0;
      check($sformatf("d1_valid_c%0d", c), valid1, 32'(c == 3));
      if (c == 3) check("d1_sample", sample1, 2'b10);
      step();
    end
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("d1_rescan_k%0d", k), valid1, 32'(k == 3));
      step();
    end
`else
    // Continuous mode, DWELL=2: valid repeats every 5 cycles until stop.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("cont_valid_c%0d", c), {valid2, busy2},
            {1'(c == 5 || c == 10 || c == 15), 1'b1});
      if (c == 5) check("cont_sample", sample2, 2'b10);
      step();
    end
    stop2 = 1'b1;
    step();
    stop2 = 1'b0;
    for (int c = 18; c <= 26; c++) begin
      check($sformatf("cont_stopped_c%0d", c), {valid2, busy2}, 2'b00);
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
